// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word read at a time to instruction
// memory and hands the returned word downstream, redirecting on branch/jump at consume.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;

    // Redirect is computed from the word being consumed; jump wins over a taken branch.
    always_comb begin
        seq_pc = instr_pc + 32'd4;
        if (jump) begin
            next_pc = {seq_pc[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = seq_pc + (branch_offset << 2);
        end else begin
            next_pc = seq_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            instruction <= 32'd0;
            instr_pc    <= 32'd0;
        end else begin
            unique case (state)
                StIdle: state <= StReq;
                StReq: begin
                    if (imem_req_ready) begin
                        state <= StWait;
                    end
                end
                // A response coincident with acceptance is never seen here: state is still StReq.
                StWait: begin
                    if (imem_resp_valid) begin
                        instruction <= imem_resp_data;
                        instr_pc    <= pc;
                        state       <= StHold;
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        pc    <= next_pc;
                        state <= StReq;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign imem_req_valid = (state == StReq);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == StHold);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: a memory responder with programmable latency,
// a transaction-level reference model compared every cycle, and literal spot checks.
module tb_mips_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_target    (jump_target)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Reference model: the architectural meaning of one fetch/consume step.
    function automatic logic [31:0] redirect(input logic [31:0] ipc, input logic j,
                                             input logic [25:0] jt, input logic bt,
                                             input logic [31:0] off);
        logic [31:0] seq;
        seq = ipc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
        if (bt) return seq + off * 32'd4;
        return seq;
    endfunction

    logic        m_boot, m_req, m_wait, m_have;
    logic [31:0] m_pc, m_inst, m_ipc;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_boot <= 1'b1; m_req <= 1'b0; m_wait <= 1'b0; m_have <= 1'b0;
            m_pc <= RESET_PC; m_inst <= 32'd0; m_ipc <= 32'd0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_req <= 1'b1;
        end else if (m_req) begin
            if (imem_req_ready) begin m_req <= 1'b0; m_wait <= 1'b1; end
        end else if (m_wait) begin
            if (imem_resp_valid) begin
                m_wait <= 1'b0; m_have <= 1'b1; m_inst <= imem_resp_data; m_ipc <= m_pc;
            end
        end else if (m_have && instr_ready) begin
            m_have <= 1'b0; m_req <= 1'b1;
            m_pc <= redirect(m_ipc, jump, jump_target, branch_taken, branch_offset);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_req_valid", {31'd0, imem_req_valid}, {31'd0, m_req});
            check("cyc_req_addr", imem_req_addr, m_pc);
            check("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
            check("cyc_instruction", instruction, m_inst);
            check("cyc_instr_pc", instr_pc, m_ipc);
        end
    end

    // Memory responder: replies k cycles after acceptance.
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr;
    logic [31:0] ovr_data;
    bit          ovr = 0;
    logic [31:0] accq[$];

    task automatic tick();
        bit          acc;
        logic [31:0] a;
        @(negedge clock);
        acc = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        @(posedge clock);
        #1;
        imem_resp_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data = ovr ? ovr_data : mem_word(pend_addr);
                ovr = 0;
            end
        end
        if (acc && reset_n) begin
            accq.push_back(a);
            pend_addr = a;
            cnt = lat;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 40) begin tick(); n++; end
        check("wait_instr_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 40) begin tick(); n++; end
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd1);
    endtask

    task automatic consume(input logic bt, input logic [31:0] off, input logic j,
                           input logic [25:0] jt);
        branch_taken = bt; branch_offset = off; jump = j; jump_target = jt;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch_taken = 1'b0; branch_offset = 32'hDEAD_0001; jump = 1'b0; jump_target = 26'h3FF_FFFF;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        chk_en = 1;
        cnt = 0;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        accq.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        instr_ready = 1'b1; branch_taken = 1'b0; branch_offset = 32'd0; jump = 1'b0;
        jump_target = 26'd0;

        // Streaming at one instruction per four cycles.
        do_reset();
        repeat (11) tick();
        check("s1_req_count", accq.size(), 32'd3);
        if (accq.size() == 3) begin
            check("s1_req0", accq[0], 32'h0);
            check("s1_req1", accq[1], 32'h4);
            check("s1_req2", accq[2], 32'h8);
        end
        instr_ready = 1'b0;

        // Request held while memory is not ready.
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        repeat (5) begin
            tick();
            check("s2_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("s2_req_addr", imem_req_addr, 32'h0);
        end
        check("s2_no_accept", accq.size(), 32'd0);
        imem_req_ready = 1'b1;

        // Downstream stall in HOLD.
        ovr = 1; ovr_data = 32'hDEAD_BEEF;
        wait_valid();
        repeat (6) begin
            tick();
            check("s3_instruction", instruction, 32'hDEAD_BEEF);
            check("s3_instr_pc", instr_pc, 32'h0);
            check("s3_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        consume(1'b0, 32'd0, 1'b0, 26'd0);
        check("s3_req_after", {31'd0, imem_req_valid}, 32'd1);
        check("s3_next_addr", imem_req_addr, 32'h4);

        // Branches around 0x100.
        wait_valid();
        consume(1'b0, 32'd0, 1'b1, 26'h0000040);
        wait_req();
        check("s4_jump_addr", imem_req_addr, 32'h100);
        wait_valid();
        consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
        wait_req();
        check("s4_back_branch", imem_req_addr, 32'h0FC);
        wait_valid();
        consume(1'b1, 32'h0, 1'b0, 26'd0);
        wait_valid();
        check("s4_pc_0x100", instr_pc, 32'h100);
        consume(1'b1, 32'h3, 1'b0, 26'd0);
        wait_req();
        check("s4_fwd_branch", imem_req_addr, 32'h110);

        // Jump beats a simultaneous taken branch.
        wait_valid();
        consume(1'b1, 32'h03FF_FFBB, 1'b0, 26'd0);
        wait_valid();
        check("s5_pc_hi", instr_pc, 32'h1000_0000);
        consume(1'b1, 32'h0000_1234, 1'b1, 26'h0000040);
        wait_req();
        check("s5_jump_wins", imem_req_addr, 32'h1000_0100);

        // Sequential wrap at the top of the address space.
        wait_valid();
        consume(1'b1, 32'h3BFF_FFBE, 1'b0, 26'd0);
        wait_valid();
        check("s6_pc_top", instr_pc, 32'hFFFF_FFFC);
        consume(1'b0, 32'd0, 1'b0, 26'd0);
        wait_req();
        check("s6_wrap", imem_req_addr, 32'h0);

        // Zero-latency and HOLD-time stray responses are ignored; longer latency.
        lat = 3;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
        tick();
        check("s7_zero_lat_ignored", {31'd0, instr_valid}, 32'd0);
        wait_valid();
        check("s7_data", instruction, 32'hFFFF_0000);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD1_BAD1;
        tick();
        check("s7_hold_stray", instruction, 32'hFFFF_0000);
        check("s7_hold_valid", {31'd0, instr_valid}, 32'd1);
        consume(1'b0, 32'd0, 1'b0, 26'd0);

        // Reset while waiting for a response, stray pulse during IDLE.
        lat = 5;
        wait_req();
        tick();
        tick();
        check("s8_in_wait", {31'd0, imem_req_valid}, 32'd0);
        do_reset();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD2_BAD2;
        tick();
        check("s8_idle_ignored", instruction, 32'd0);
        check("s8_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("s8_req_addr", imem_req_addr, RESET_PC);
        lat = 1;
        wait_valid();
        check("s8_instr_pc", instr_pc, RESET_PC);
        consume(1'b0, 32'd0, 1'b0, 26'd0);
        repeat (3) tick();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
